instr_fetch_unit: RTL and testbench



---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_queue.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

endpackage

// File: rtl/ifu_queue.sv
// Prefetch FIFO holding {pc, word} pairs; flush dominates push, head is a registered entry.
module ifu_queue #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  // A slot freed by a same-cycle pop may be refilled immediately.
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher with prefetch queue and redirect flush.
// Optional performance counters enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic              q_full_s;
  logic              q_empty_s;
  logic [CW-1:0]     q_count_s;
  logic [2*XLEN-1:0] q_rdata_s;
  logic              push_s;
  logic              pop_s;
  logic              room_after_push_s;
  logic [XLEN-1:0]   target_s;

  assign instr_valid       = !q_empty_s;
  assign instr_pc          = q_rdata_s[2*XLEN-1:XLEN];
  assign instruction       = q_rdata_s[XLEN-1:0];
  assign imem_req          = (state_q == REQ);
  assign imem_addr         = fetch_pc_q;
  assign pop_s             = instr_valid && instr_ready && !redirect;
  assign target_s          = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign room_after_push_s = (q_count_s + CW'(1) - CW'(pop_s)) < CW'(QDEPTH);

  ifu_queue #(
    .DW    (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect),
    .wdata_i ({inflight_pc_q, imem_rdata}),
    .rdata_o (q_rdata_s),
    .full_o  (q_full_s),
    .empty_o (q_empty_s),
    .count_o (q_count_s)
  );

  // Fetch FSM next-state; an entry is reserved before each request so pushes never overflow.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    push_s        = 1'b0;
    if (redirect) begin
      fetch_pc_d = target_s;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_gnt    ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid ? REQ   : DRAIN;
        DRAIN:   state_d = imem_rvalid ? REQ   : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (!q_full_s) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
            state_d       = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push_s  = 1'b1;
            state_d = room_after_push_s ? REQ : IDLE;
          end else begin
            state_d = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_d = REQ;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Pushed-word and empty-head cycle counters, both wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (push_s) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (!instr_valid) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple grant/rvalid memory model.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          wcnt      = 0;
  int          resp_cnt  = 0;
  bit          resp_pend = 1'b0;
  logic [31:0] resp_addr = 32'd0;
  logic [31:0] gnt_log [$];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  // Memory model: drives gnt/rvalid on the falling edge, one response per grant.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        resp_pend   = 1'b0;
        resp_cnt    = 0;
        wcnt        = 0;
        gnt_log.delete();
      end else begin
        imem_rvalid = 1'b0;
        if (resp_pend) begin
          if (resp_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(resp_addr);
            resp_pend   = 1'b0;
          end else begin
            resp_cnt = resp_cnt - 1;
          end
        end
        imem_gnt = 1'b0;
        if (imem_req) begin
          if (wcnt >= gnt_delay) begin
            imem_gnt  = 1'b1;
            wcnt      = 0;
            resp_pend = 1'b1;
            resp_cnt  = rv_delay;
            resp_addr = imem_addr;
            gnt_log.push_back(imem_addr);
          end else begin
            wcnt = wcnt + 1;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 30) begin
      step(1);
      n++;
    end
    chk(tag, imem_req, 32'd1);
  endtask

  task automatic pop_expect(input logic [31:0] pc);
    int n = 0;
    while (!instr_valid && n < 30) begin
      step(1);
      n++;
    end
    chk("pop_valid", instr_valid, 32'd1);
    chk("pop_pc", instr_pc, pc);
    chk("pop_word", instruction, mem_word(pc));
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    // Reset values
    step(2);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", instr_valid, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: first fetches and 3-cycle latency
    step(1);
    chk("t1_req_c1", imem_req, 32'd1);
    chk("t1_addr_c1", imem_addr, 32'h0);
    step(1);
    chk("t1_valid_c2", instr_valid, 32'd0);
    step(1);
    chk("t1_valid_c3", instr_valid, 32'd1);
    chk("t1_pc_c3", instr_pc, 32'h0);
    chk("t1_word_c3", instruction, mem_word(32'h0));
    chk("t1_req_c3", imem_req, 32'd1);
    chk("t1_addr_c3", imem_addr, 32'h4);

    // Test 2: backpressure fills exactly QDEPTH entries
    step(4);
    chk("t2_req_idle", imem_req, 32'd0);
    chk("t2_gnts", gnt_log.size(), 32'd2);
    chk("t2_head_pc", instr_pc, 32'h0);
    pop_expect(32'h0);
    step(6);
    chk("t2_gnts_after_pop", gnt_log.size(), 32'd3);
    chk("t2_gnt2_addr", gnt_log[2], 32'h8);
    chk("t2_req_idle2", imem_req, 32'd0);
    pop_expect(32'h4);
    pop_expect(32'h8);
    pop_expect(32'hc);
    step(10);
    chk("t2_gnts_total", gnt_log.size(), 32'd6);
    chk("t2_gnt_last", gnt_log[5], 32'h14);

    // Test 3: delayed grant keeps request stable
    gnt_delay = 3;
    pop_expect(32'h10);
    wait_req("t3_req_start");
    for (int i = 0; i < 4; i++) begin
      chk("t3_req_hold", imem_req, 32'd1);
      chk("t3_addr_hold", imem_addr, 32'h18);
      step(1);
    end
    chk("t3_req_after_gnt", imem_req, 32'd0);
    step(4);
    pop_expect(32'h14);
    wait_req("t3_req_next");
    chk("t3_addr_next", imem_addr, 32'h1c);
    step(8);
    gnt_delay = 0;

    // Test 4: redirect while waiting for a slow response
    rv_delay = 2;
    pop_expect(32'h18);
    wait_req("t4_req");
    chk("t4_inflight_addr", imem_addr, 32'h20);
    step(1);
    chk("t4_in_wait", imem_req, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step(1);
    redirect = 1'b0;
    rv_delay = 0;
    chk("t4_flushed", instr_valid, 32'd0);
    chk("t4_drain_noreq", imem_req, 32'd0);
    wait_req("t4_req_new");
    chk("t4_addr_new", imem_addr, 32'h100);
    pop_expect(32'h100);

    // Test 5: redirect coincident with pop and rvalid
    for (int i = 0; i < 20; i++) begin
      if (resp_pend && resp_cnt == 0 && instr_valid) break;
      step(1);
    end
    chk("t5_setup", {30'd0, resp_pend, instr_valid}, 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    instr_ready = 1'b1;
    step(1);
    redirect    = 1'b0;
    instr_ready = 1'b0;
    chk("t5_empty", instr_valid, 32'd0);
    chk("t5_req", imem_req, 32'd1);
    chk("t5_addr", imem_addr, 32'h200);
    pop_expect(32'h200);
    pop_expect(32'h204);

    // Test 6: asynchronous reset mid-WAIT
    wait_req("t6_req");
    step(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_req", imem_req, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", instr_valid, 32'd0);
    chk("t6_instr", instruction, 32'd0);
    chk("t6_pc", instr_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("t6_perf_fetch_rst", perf_fetch_cnt, 32'd0);
    chk("t6_perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(20);
    chk("t6_idle", imem_req, 32'd0);
    chk("t6_gnts", gnt_log.size(), 32'd2);
    chk("t6_gnt0", gnt_log[0], 32'h0);
    chk("t6_gnt1", gnt_log[1], 32'h4);
`ifdef IFU_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch_cnt, 32'd2);
    chk("t6_perf_stall", perf_stall_cnt, 32'd3);
`endif
    pop_expect(32'h0);
    pop_expect(32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
